// File: rtl/mem_req_pkg.sv
// Shared definitions for the EXE-stage data-SRAM request unit: one-hot op
// bit positions, bus size codes, FSM state encoding and the op decode helpers.
// Optional feature macro used by this slice: MEM_REQ_ALE_CHECK_EN.
package mem_req_pkg;

    // Bit positions inside the one-hot op vector {st_w,st_h,st_b,ld_hu,ld_bu,ld_h,ld_b,ld_w}
    localparam int OP_LD_W  = 0;
    localparam int OP_LD_B  = 1;
    localparam int OP_LD_H  = 2;
    localparam int OP_LD_BU = 3;
    localparam int OP_LD_HU = 4;
    localparam int OP_ST_B  = 5;
    localparam int OP_ST_H  = 6;
    localparam int OP_ST_W  = 7;

    // Bus size codes
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Request FSM encoding; S_CANCEL keeps a squashed request on the bus until addr_ok
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_DONE   = 2'd2,
        S_CANCEL = 2'd3
    } state_e;

    // Access width of an op; anything not half or word is treated as a byte access
    function automatic logic [1:0] op_size(input logic [7:0] op);
        if (op[OP_LD_W] || op[OP_ST_W]) begin
            return SIZE_W;
        end else if (op[OP_LD_H] || op[OP_LD_HU] || op[OP_ST_H]) begin
            return SIZE_H;
        end
        return SIZE_B;
    endfunction

    // Address not naturally aligned for the access width
    function automatic logic op_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
        logic [1:0] size;
        size = op_size(op);
        if (size == SIZE_W) begin
            return addr_lo != 2'b00;
        end else if (size == SIZE_H) begin
            return addr_lo[0];
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational bus-field formatter: turns a held op, its effective address and
// store data into size, byte strobes, replicated write data and the bus address.
// Without MEM_REQ_ALE_CHECK_EN the bus address is forced to natural alignment.
module store_align
    import mem_req_pkg::*;
(
    input  logic [7:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    output logic        wr,
    output logic [1:0]  size,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] bus_addr
);

    // Derive all bus fields from op width and the low address bits
    always_comb begin
        size     = op_size(op);
        wr       = op[OP_ST_B] | op[OP_ST_H] | op[OP_ST_W];
        bus_addr = addr;
`ifndef MEM_REQ_ALE_CHECK_EN
        if (size == SIZE_H) begin
            bus_addr[0] = 1'b0;
        end else if (size == SIZE_W) begin
            bus_addr[1:0] = 2'b00;
        end
`endif
        case (size)
            SIZE_H: begin
                wdata = {2{st_data[15:0]}};
                wstrb = addr[1] ? 4'b1100 : 4'b0011;
            end
            SIZE_W: begin
                wdata = st_data;
                wstrb = 4'b1111;
            end
            default: begin
                wdata = {4{st_data[7:0]}};
                wstrb = 4'b0001 << addr[1:0];
            end
        endcase
        // Loads never write any byte lane
        if (!wr) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/exe_mem_req.sv
// EXE-stage data-SRAM request unit. Holds one op at a time, issues memory ops on
// the req/addr_ok/data_ok bus, hands the load descriptor to MEM, and masks
// data_ok responses that belong to squashed requests.
// Handshake: an op moves on in_valid & in_ready; MEM takes it on out_valid & out_ready;
// a bus request completes on data_sram_req & data_sram_addr_ok and, once raised, req
// and every bus field stay frozen until that happens.
// Optional feature: MEM_REQ_ALE_CHECK_EN (misaligned-address exception instead of a bus request).
module exe_mem_req
    import mem_req_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_is_mem,
    input  logic [7:0]  in_op,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_st_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_load,
    output logic        out_wait_data,
    output logic        out_ale,
    output logic        out_data_ok,
    output logic        data_sram_req,
    output logic        data_sram_wr,
    output logic [1:0]  data_sram_size,
    output logic [3:0]  data_sram_wstrb,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic        data_sram_addr_ok,
    input  logic        data_sram_data_ok
);

    localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

    state_e      state_q, state_d, accept_state;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic [1:0]  cancel_cnt_q, cancel_cnt_d;
    logic [7:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] st_data_q, st_data_d;
    logic        is_mem_q, is_mem_d;
    logic        ale_q, ale_d;
    logic        accept, req_fire, in_ale, cancel_inc, cancel_dec;

`ifdef MEM_REQ_ALE_CHECK_EN
    assign in_ale = in_is_mem & op_misaligned(in_op, in_addr[1:0]);
`else
    assign in_ale = 1'b0;
`endif

    // A flush squashes the op presented in the same cycle as well
    assign accept       = in_valid & in_ready & ~flush;
    assign req_fire     = data_sram_req & data_sram_addr_ok;
    assign accept_state = (in_is_mem && !in_ale) ? S_REQ : S_DONE;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        cancel_inc = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = accept_state;
            end
            S_REQ: begin
                if (flush) begin
                    if (req_fire) begin
                        state_d    = S_IDLE;
                        cancel_inc = 1'b1;
                    end else if (data_sram_req) begin
                        state_d = S_CANCEL;
                    end else begin
                        // Nothing has been put on the bus yet, so nothing to track
                        state_d = S_IDLE;
                    end
                end else if (req_fire) begin
                    state_d = S_DONE;
                end
            end
            S_CANCEL: begin
                if (req_fire) begin
                    state_d    = S_IDLE;
                    cancel_inc = 1'b1;
                end
            end
            S_DONE: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (out_ready) begin
                    state_d = accept ? accept_state : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake and bus-request outputs
    always_comb begin
        in_ready      = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready && !flush);
        out_valid     = (state_q == S_DONE) && !flush;
        data_sram_req = ((state_q == S_REQ) || (state_q == S_CANCEL)) && (out_cnt_q < MAX_CNT);
    end

    // Capture the op on acceptance; hold it otherwise so the bus fields stay frozen
    always_comb begin
        op_d      = op_q;
        addr_d    = addr_q;
        st_data_d = st_data_q;
        is_mem_d  = is_mem_q;
        ale_d     = ale_q;
        if (accept) begin
            op_d      = in_op;
            addr_d    = in_addr;
            st_data_d = in_st_data;
            is_mem_d  = in_is_mem;
            ale_d     = in_ale;
        end
    end

    // Outstanding and cancelled transaction counters
    always_comb begin
        cancel_dec = data_sram_data_ok && (cancel_cnt_q != 2'd0);
        out_cnt_d  = out_cnt_q;
        if (req_fire && !data_sram_data_ok) begin
            out_cnt_d = out_cnt_q + 2'd1;
        end else if (!req_fire && data_sram_data_ok && (out_cnt_q != 2'd0)) begin
            out_cnt_d = out_cnt_q - 2'd1;
        end
        cancel_cnt_d = cancel_cnt_q;
        if (cancel_inc && !cancel_dec) begin
            cancel_cnt_d = cancel_cnt_q + 2'd1;
        end else if (!cancel_inc && cancel_dec) begin
            cancel_cnt_d = cancel_cnt_q - 2'd1;
        end
    end

    // Datapath and counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q         <= '0;
            addr_q       <= '0;
            st_data_q    <= '0;
            is_mem_q     <= 1'b0;
            ale_q        <= 1'b0;
            out_cnt_q    <= 2'd0;
            cancel_cnt_q <= 2'd0;
        end else begin
            op_q         <= op_d;
            addr_q       <= addr_d;
            st_data_q    <= st_data_d;
            is_mem_q     <= is_mem_d;
            ale_q        <= ale_d;
            out_cnt_q    <= out_cnt_d;
            cancel_cnt_q <= cancel_cnt_d;
        end
    end

    store_align u_store_align (
        .op       (op_q),
        .addr     (addr_q),
        .st_data  (st_data_q),
        .wr       (data_sram_wr),
        .size     (data_sram_size),
        .wstrb    (data_sram_wstrb),
        .wdata    (data_sram_wdata),
        .bus_addr (data_sram_addr)
    );

    assign out_load      = {addr_q[1:0], op_q[OP_LD_HU:OP_LD_W]};
    assign out_wait_data = is_mem_q & ~ale_q;
    assign out_ale       = ale_q;
    assign out_data_ok   = data_sram_data_ok & (cancel_cnt_q == 2'd0);

endmodule

// File: tb/tb_exe_mem_req.sv
// Bench for exe_mem_req: directed scenarios plus a randomized op stream checked
// against a behavioural model of the bus formatting rules and a response queue.
module tb_exe_mem_req;

    localparam int MAXO = 2;
`ifdef MEM_REQ_ALE_CHECK_EN
    localparam bit ALE_EN = 1'b1;
`else
    localparam bit ALE_EN = 1'b0;
`endif
    localparam logic [7:0] LD_W = 8'h01;
    localparam logic [7:0] LD_H = 8'h04;
    localparam logic [7:0] ST_B = 8'h20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, in_valid = 1'b0, in_is_mem = 1'b0, out_ready = 1'b0;
    logic [7:0]  in_op = '0;
    logic [31:0] in_addr = '0, in_st_data = '0;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic        in_ready, out_valid, out_wait_data, out_ale, out_data_ok;
    logic [6:0]  out_load;
    logic        req, wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] baddr, wdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    exe_mem_req #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_is_mem(in_is_mem),
        .in_op(in_op), .in_addr(in_addr), .in_st_data(in_st_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_load(out_load),
        .out_wait_data(out_wait_data), .out_ale(out_ale), .out_data_ok(out_data_ok),
        .data_sram_req(req), .data_sram_wr(wr), .data_sram_size(size),
        .data_sram_wstrb(wstrb), .data_sram_addr(baddr), .data_sram_wdata(wdata),
        .data_sram_addr_ok(addr_ok), .data_sram_data_ok(data_ok)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: still running at %0t, required finish earlier", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d, input logic mem);
        in_valid   = 1'b1;
        in_op      = op;
        in_addr    = a;
        in_st_data = d;
        in_is_mem  = mem;
    endtask

    // Behavioural model of the bus fields, from access width and arithmetic
    function automatic void ref_bus(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                                    output logic e_wr, output logic [1:0] e_size, output logic [3:0] e_strb,
                                    output logic [31:0] e_addr, output logic [31:0] e_wdata, output logic e_mis);
        int unsigned bytes;
        int unsigned aligned;
        bytes   = (op[1] | op[3] | op[5]) ? 1 : (op[2] | op[4] | op[6]) ? 2 : 4;
        e_size  = (bytes == 1) ? 2'd0 : (bytes == 2) ? 2'd1 : 2'd2;
        e_wr    = |op[7:5];
        e_mis   = (a % bytes) != 0;
        aligned = a - (a % bytes);
        e_addr  = ALE_EN ? a : aligned;
        e_strb  = e_wr ? 4'((((32'd1 << bytes) - 32'd1) << (aligned % 4))) : 4'd0;
        e_wdata = (bytes == 1) ? 32'(d[7:0]) * 32'h01010101 :
                  (bytes == 2) ? 32'(d[15:0]) * 32'h00010001 : d;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (3) tick();
        settle();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", req); end
        checks++; if ({out_load, out_wait_data, out_ale, out_data_ok} !== 10'd0) begin errors++; $display("FAIL reset_mem_side: got %h want 0", {out_load, out_wait_data, out_ale, out_data_ok}); end
        checks++; if ({wr, size, wstrb, baddr, wdata} !== 71'd0) begin errors++; $display("FAIL reset_bus_fields: got %h want 0", {wr, size, wstrb, baddr, wdata}); end
        tick();
        rst = 1'b1;
    endtask

    task automatic test_store_byte();
        tick(); drive_op(ST_B, 32'h1003, 32'h12345678, 1'b1);
        tick(); in_valid = 1'b0; addr_ok = 1'b1; settle();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL stb_req: got %b want 1", req); end
        checks++; if ({wr, size, wstrb} !== {1'b1, 2'd0, 4'b1000}) begin errors++; $display("FAIL stb_ctl: got %b want %b", {wr, size, wstrb}, 7'b1001000); end
        checks++; if (wdata !== 32'h78787878) begin errors++; $display("FAIL stb_wdata: got %h want 78787878", wdata); end
        checks++; if (baddr !== 32'h1003) begin errors++; $display("FAIL stb_addr: got %h want 00001003", baddr); end
        tick(); addr_ok = 1'b0; out_ready = 1'b1; settle();
        checks++; if ({out_valid, out_wait_data, out_load} !== {2'b11, 7'b1100000}) begin errors++; $display("FAIL stb_handoff: got %b want %b", {out_valid, out_wait_data, out_load}, 9'b111100000); end
        tick(); out_ready = 1'b0; data_ok = 1'b1; settle();
        checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL stb_data_ok: got %b want 1", out_data_ok); end
        tick(); data_ok = 1'b0;
    endtask

    task automatic test_load_half_delay();
        tick(); drive_op(LD_H, 32'h2002, 32'hdeadbeef, 1'b1);
        tick(); in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            addr_ok = (k == 3);
            settle();
            checks++; if ({req, wr, size, wstrb, baddr} !== {1'b1, 1'b0, 2'd1, 4'd0, 32'h2002}) begin errors++; $display("FAIL ldh_hold_%0d: got %h want %h", k, {req, wr, size, wstrb, baddr}, {1'b1, 1'b0, 2'd1, 4'd0, 32'h2002}); end
            tick();
        end
        addr_ok = 1'b0; out_ready = 1'b1; settle();
        checks++; if ({out_valid, out_load} !== {1'b1, 7'b1000100}) begin errors++; $display("FAIL ldh_out_load: got %b want %b", {out_valid, out_load}, 8'b11000100); end
        tick(); out_ready = 1'b0; data_ok = 1'b1; settle();
        checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL ldh_data_ok: got %b want 1", out_data_ok); end
        tick(); data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        tick(); drive_op(LD_W, 32'h100, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; addr_ok = 1'b1; settle();
        checks++; if ({req, baddr} !== {1'b1, 32'h100}) begin errors++; $display("FAIL b2b_req1: got %h want %h", {req, baddr}, {1'b1, 32'h100}); end
        tick(); addr_ok = 1'b0; out_ready = 1'b1; drive_op(LD_W, 32'h104, 32'h0, 1'b1); settle();
        checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_accept2: got %b want 11", {out_valid, in_ready}); end
        tick(); in_valid = 1'b0; out_ready = 1'b0; addr_ok = 1'b1; settle();
        checks++; if ({req, baddr} !== {1'b1, 32'h104}) begin errors++; $display("FAIL b2b_req2: got %h want %h", {req, baddr}, {1'b1, 32'h104}); end
        tick(); addr_ok = 1'b0; out_ready = 1'b1; drive_op(LD_W, 32'h108, 32'h0, 1'b1); settle();
        checks++; if ({out_valid, in_ready} !== 2'b11) begin errors++; $display("FAIL b2b_accept3: got %b want 11", {out_valid, in_ready}); end
        tick(); in_valid = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++; if (req !== 1'b0) begin errors++; $display("FAIL b2b_blocked_%0d: got %b want 0", k, req); end
            tick();
        end
        data_ok = 1'b1; settle();
        checks++; if ({out_data_ok, req} !== 2'b10) begin errors++; $display("FAIL b2b_first_resp: got %b want 10", {out_data_ok, req}); end
        tick(); data_ok = 1'b0; addr_ok = 1'b1; settle();
        checks++; if ({req, baddr} !== {1'b1, 32'h108}) begin errors++; $display("FAIL b2b_req3: got %h want %h", {req, baddr}, {1'b1, 32'h108}); end
        tick(); addr_ok = 1'b0; out_ready = 1'b1; settle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_handoff3: got %b want 1", out_valid); end
        tick(); out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            data_ok = 1'b1; settle();
            checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL b2b_drain_%0d: got %b want 1", k, out_data_ok); end
            tick(); data_ok = 1'b0;
        end
    endtask

    task automatic test_flush_cancel();
        // flush while the request waits for addr_ok
        tick(); drive_op(LD_W, 32'h200, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; flush = 1'b1; settle();
        checks++; if ({req, out_valid} !== 2'b10) begin errors++; $display("FAIL flush_req_kept: got %b want 10", {req, out_valid}); end
        tick(); flush = 1'b0; settle();
        checks++; if ({req, in_ready, baddr} !== {2'b10, 32'h200}) begin errors++; $display("FAIL flush_cancel_hold: got %h want %h", {req, in_ready, baddr}, {2'b10, 32'h200}); end
        tick(); addr_ok = 1'b1; settle();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL flush_cancel_req: got %b want 1", req); end
        tick(); addr_ok = 1'b0; settle();
        checks++; if ({in_ready, out_valid, req} !== 3'b100) begin errors++; $display("FAIL flush_back_idle: got %b want 100", {in_ready, out_valid, req}); end
        // a live load follows; its response is the second one
        tick(); drive_op(LD_W, 32'h300, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; addr_ok = 1'b1;
        tick(); addr_ok = 1'b0; out_ready = 1'b1;
        tick(); out_ready = 1'b0; data_ok = 1'b1; settle();
        checks++; if (out_data_ok !== 1'b0) begin errors++; $display("FAIL flush_masked: got %b want 0", out_data_ok); end
        tick(); settle();
        checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL flush_live_resp: got %b want 1", out_data_ok); end
        tick(); data_ok = 1'b0;
        // flush and addr_ok in the same cycle
        drive_op(LD_W, 32'h400, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; flush = 1'b1; addr_ok = 1'b1; settle();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL flush_same_req: got %b want 1", req); end
        tick(); flush = 1'b0; addr_ok = 1'b0; settle();
        checks++; if ({in_ready, out_valid} !== 2'b10) begin errors++; $display("FAIL flush_same_idle: got %b want 10", {in_ready, out_valid}); end
        tick(); data_ok = 1'b1; settle();
        checks++; if (out_data_ok !== 1'b0) begin errors++; $display("FAIL flush_same_masked: got %b want 0", out_data_ok); end
        tick(); data_ok = 1'b0;
    endtask

    task automatic test_align();
        tick(); drive_op(LD_W, 32'h3001, 32'h0, 1'b1);
        tick(); in_valid = 1'b0;
        if (ALE_EN) begin
            settle();
            checks++; if ({req, out_valid, out_ale, out_wait_data} !== 4'b0110) begin errors++; $display("FAIL ale_raise: got %b want 0110", {req, out_valid, out_ale, out_wait_data}); end
            tick(); out_ready = 1'b1;
            tick(); out_ready = 1'b0;
        end else begin
            addr_ok = 1'b1; settle();
            checks++; if ({req, baddr} !== {1'b1, 32'h3000}) begin errors++; $display("FAIL align_addr: got %h want %h", {req, baddr}, {1'b1, 32'h3000}); end
            tick(); addr_ok = 1'b0; out_ready = 1'b1; settle();
            checks++; if ({out_valid, out_ale, out_wait_data, out_load} !== {3'b101, 7'b0100001}) begin errors++; $display("FAIL align_handoff: got %b want %b", {out_valid, out_ale, out_wait_data, out_load}, {3'b101, 7'b0100001}); end
            tick(); out_ready = 1'b0; data_ok = 1'b1;
            tick(); data_ok = 1'b0;
        end
    endtask

    task automatic test_random();
        logic [7:0]  op;
        logic [31:0] a, d, e_addr, e_wdata;
        logic        mem, e_wr, e_mis, e_ale, e_req;
        logic [1:0]  e_size;
        logic [3:0]  e_strb;
        int unsigned dly;
        for (int n = 0; n < 40; n++) begin
            mem = ($urandom_range(0, 3) != 0);
            op  = 8'd1 << $urandom_range(0, 7);
            a   = $urandom;
            d   = $urandom;
            ref_bus(op, a, d, e_wr, e_size, e_strb, e_addr, e_wdata, e_mis);
            e_ale = ALE_EN & mem & e_mis;
            e_req = mem & ~e_ale;
            tick(); drive_op(op, a, d, mem); settle();
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_in_ready_%0d: got %b want 1", n, in_ready); end
            tick(); in_valid = 1'b0;
            if (e_req) begin
                dly = $urandom_range(0, 3);
                for (int k = 0; k <= int'(dly); k++) begin
                    addr_ok = (k == int'(dly));
                    settle();
                    checks++; if ({req, out_valid, wr, size, wstrb, baddr} !== {2'b10, e_wr, e_size, e_strb, e_addr}) begin errors++; $display("FAIL rnd_bus_%0d: got %h want %h", n, {req, out_valid, wr, size, wstrb, baddr}, {2'b10, e_wr, e_size, e_strb, e_addr}); end
                    if (e_wr) begin
                        checks++; if (wdata !== e_wdata) begin errors++; $display("FAIL rnd_wdata_%0d: got %h want %h", n, wdata, e_wdata); end
                    end
                    tick();
                end
                addr_ok = 1'b0;
                exp_q.push_back(e_addr);
            end
            dly = $urandom_range(0, 2);
            for (int k = 0; k <= int'(dly); k++) begin
                out_ready = (k == int'(dly));
                settle();
                checks++; if ({out_valid, req} !== 2'b10) begin errors++; $display("FAIL rnd_done_%0d: got %b want 10", n, {out_valid, req}); end
                if (k == int'(dly)) begin
                    checks++; if ({out_load, out_wait_data, out_ale} !== {a[1:0], op[4:0], e_req, e_ale}) begin errors++; $display("FAIL rnd_desc_%0d: got %b want %b", n, {out_load, out_wait_data, out_ale}, {a[1:0], op[4:0], e_req, e_ale}); end
                end
                tick();
            end
            out_ready = 1'b0;
            while (exp_q.size() >= MAXO || (exp_q.size() > 0 && $urandom_range(0, 1) == 1)) begin
                data_ok = 1'b1; settle();
                checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL rnd_resp_%h: got %b want 1", exp_q[0], out_data_ok); end
                void'(exp_q.pop_front());
                tick(); data_ok = 1'b0;
            end
        end
        while (exp_q.size() > 0) begin
            data_ok = 1'b1; settle();
            checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL rnd_drain_%h: got %b want 1", exp_q[0], out_data_ok); end
            void'(exp_q.pop_front());
            tick(); data_ok = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        // leave one cancelled transaction outstanding, then reset mid-request
        drive_op(LD_W, 32'h600, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; flush = 1'b1; addr_ok = 1'b1;
        tick(); flush = 1'b0; addr_ok = 1'b0; drive_op(LD_W, 32'h604, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; settle();
        checks++; if (req !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %b want 1", req); end
        rst = 1'b0; #1;
        checks++; if ({req, in_ready, out_valid} !== 3'b010) begin errors++; $display("FAIL arst_immediate: got %b want 010", {req, in_ready, out_valid}); end
        tick(); tick(); rst = 1'b1;
        tick(); drive_op(LD_W, 32'h700, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; addr_ok = 1'b1;
        tick(); addr_ok = 1'b0; out_ready = 1'b1; drive_op(LD_W, 32'h704, 32'h0, 1'b1);
        tick(); in_valid = 1'b0; out_ready = 1'b0; addr_ok = 1'b1; settle();
        checks++; if ({req, baddr} !== {1'b1, 32'h704}) begin errors++; $display("FAIL arst_out_cnt: got %h want %h", {req, baddr}, {1'b1, 32'h704}); end
        tick(); addr_ok = 1'b0; out_ready = 1'b1;
        tick(); out_ready = 1'b0; data_ok = 1'b1; settle();
        checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL arst_cancel_cnt: got %b want 1", out_data_ok); end
        tick(); settle();
        checks++; if (out_data_ok !== 1'b1) begin errors++; $display("FAIL arst_second_resp: got %b want 1", out_data_ok); end
        tick(); data_ok = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_store_byte();
        test_load_half_delay();
        test_back_to_back();
        test_flush_cancel();
        test_align();
        test_random();
        test_async_reset();
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
